model_share_arbiter: RTL and testbench

//  Shares one instance of the mixed-range bus resource (operands i0[MSB:LSB], i1[LSB:MSB];

---
 rtl/model_share_arbiter.sv | 118 +++++++++++
 tb/tb_model_share_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/model_share_arbiter.sv
// rtl/model_share_arbiter.sv - round-robin sharing of one start/done resource between two requesters
// Optional WAIT timeout abort enabled by defining MODEL_ARB_TIMEOUT_EN.
module model_share_arbiter #(
  parameter int MSB       = 2,
  parameter int LSB       = -2,
  parameter bit PRIO_INIT = 1'b0,
  parameter int TIMEOUT   = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [MSB:LSB] req0_i0,
  input  logic [LSB:MSB] req0_i1,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [MSB:LSB] req1_i0,
  input  logic [LSB:MSB] req1_i1,
  output logic           res_start,
  output logic [MSB:LSB] res_i0,
  output logic [LSB:MSB] res_i1,
  input  logic           res_done,
  input  logic [MSB:LSB] res_o0,
  input  logic [LSB:MSB] res_o1,
  output logic [1:0]     rsp_valid,
  output logic [MSB:LSB] rsp_o0,
  output logic [LSB:MSB] rsp_o1,
  output logic           rsp_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t state;
  logic   gnt;
  logic   last_gnt;
  logic   take0;
  logic   take1;
  logic   expired;

  // On a tie the requester that was not granted last time wins.
  always_comb begin
    take0 = 1'b0;
    take1 = 1'b0;
    if (!rst && state == S_IDLE) begin
      take0 = req0_valid && (!req1_valid || last_gnt);
      take1 = req1_valid && (!req0_valid || !last_gnt);
    end
  end

  assign req0_ready = take0;
  assign req1_ready = take1;

`ifdef MODEL_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] wait_cnt;
  assign expired = (state == S_WAIT) && (wait_cnt == CW'(TIMEOUT - 1));
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      gnt       <= 1'b0;
      last_gnt  <= ~PRIO_INIT;
      res_start <= 1'b0;
      res_i0    <= '0;
      res_i1    <= '0;
      rsp_valid <= 2'b00;
      rsp_o0    <= '0;
      rsp_o1    <= '0;
      rsp_err   <= 1'b0;
`ifdef MODEL_ARB_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      res_start <= 1'b0;
      rsp_valid <= 2'b00;
      rsp_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (take0 || take1) begin
            gnt       <= take1;
            res_i0    <= take1 ? req1_i0 : req0_i0;
            res_i1    <= take1 ? req1_i1 : req0_i1;
            res_start <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
`ifdef MODEL_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        S_WAIT: begin
          // A done arriving on the expiry cycle still returns real data.
          if (res_done || expired) begin
            rsp_valid <= gnt ? 2'b10 : 2'b01;
            rsp_err   <= !res_done;
            rsp_o0    <= res_done ? res_o0 : '0;
            rsp_o1    <= res_done ? res_o1 : '0;
            state     <= S_RESP;
          end
`ifdef MODEL_ARB_TIMEOUT_EN
          wait_cnt <= wait_cnt + 1'b1;
`endif
        end
        S_RESP: begin
          last_gnt <= gnt;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_model_share_arbiter.sv
// tb/tb_model_share_arbiter.sv - directed and randomized bench for model_share_arbiter
// Expected timeout behaviour follows MODEL_ARB_TIMEOUT_EN when defined.
module tb_model_share_arbiter;
  localparam int MSB = 2;
  localparam int LSB = -2;
  localparam int W = MSB - LSB + 1;
  localparam int TIMEOUT = 15;
`ifdef MODEL_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           req0_valid, req0_ready, req1_valid, req1_ready;
  logic [MSB:LSB] req0_i0, req1_i0, res_i0, res_o0, rsp_o0;
  logic [LSB:MSB] req0_i1, req1_i1, res_i1, res_o1, rsp_o1;
  logic           res_start, res_done, rsp_err;
  logic [1:0]     rsp_valid;

  int checks = 0;
  int errors = 0;
  bit last;

  always #5 clk = ~clk;

  model_share_arbiter #(.MSB(MSB), .LSB(LSB), .PRIO_INIT(1'b0), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_i0(req0_i0), .req0_i1(req0_i1),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_i0(req1_i0), .req1_i1(req1_i1),
    .res_start(res_start), .res_i0(res_i0), .res_i1(res_i1),
    .res_done(res_done), .res_o0(res_o0), .res_o1(res_o1),
    .rsp_valid(rsp_valid), .rsp_o0(rsp_o0), .rsp_o1(rsp_o1), .rsp_err(rsp_err)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction: winner from round-robin rule, response after d+1 WAIT cycles (or timeout).
  task automatic run_txn(input bit v0, input bit v1,
                         input logic [MSB:LSB] a0, input logic [LSB:MSB] a1,
                         input logic [MSB:LSB] b0, input logic [LSB:MSB] b1,
                         input int d, input logic [MSB:LSB] o0, input logic [LSB:MSB] o1);
    bit w, err;
    int nw;
    logic [MSB:LSB] x0;
    logic [LSB:MSB] x1;
    w   = (v0 && v1) ? !last : v1;
    x0  = w ? b0 : a0;
    x1  = w ? b1 : a1;
    err = TO_EN && (d + 1 > TIMEOUT);
    nw  = err ? TIMEOUT : d + 1;
    req0_valid = v0; req1_valid = v1;
    req0_i0 = a0; req0_i1 = a1; req1_i0 = b0; req1_i1 = b1;
    #1;
    chk("grant_ready0", req0_ready, w == 1'b0);
    chk("grant_ready1", req1_ready, w == 1'b1);
    step();
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_i0 = W'($urandom); req0_i1 = W'($urandom);
    req1_i0 = W'($urandom); req1_i1 = W'($urandom);
    res_done = 1'b1; res_o0 = W'($urandom); res_o1 = W'($urandom);
    #1;
    chk("issue_start", res_start, 1'b1);
    chk("issue_i0", res_i0, x0);
    chk("issue_i1", res_i1, x1);
    chk("issue_ready", {req0_ready, req1_ready}, 2'b00);
    step();
    for (int k = 1; k <= nw; k++) begin
      chk("wait_start", res_start, 1'b0);
      chk("wait_i0", res_i0, x0);
      chk("wait_i1", res_i1, x1);
      chk("wait_ready", {req0_ready, req1_ready}, 2'b00);
      chk("wait_rsp", rsp_valid, 2'b00);
      res_done = (k == nw) && !err;
      res_o0 = o0; res_o1 = o1;
      step();
      res_done = 1'b0; res_o0 = W'($urandom); res_o1 = W'($urandom);
    end
    chk("resp_valid", rsp_valid, w ? 2'b10 : 2'b01);
    chk("resp_err", rsp_err, err);
    chk("resp_o0", rsp_o0, err ? '0 : o0);
    chk("resp_o1", rsp_o1, err ? '0 : o1);
    chk("resp_ready", {req0_ready, req1_ready}, 2'b00);
    last = w;
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("idle_rsp", rsp_valid, 2'b00);
    chk("idle_err", rsp_err, 1'b0);
    chk("idle_o0_hold", rsp_o0, err ? '0 : o0);
    chk("idle_i0_hold", res_i0, x0);
  endtask

  initial begin
    logic [LSB:MSB] v1b;
    logic [MSB:LSB] r0, r1;
    logic [LSB:MSB] s0, s1;
    bit rv0, rv1;
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_i0 = '0; req0_i1 = '0; req1_i0 = '0; req1_i1 = '0;
    res_done = 1'b0; res_o0 = '0; res_o1 = '0;
    step(); step();
    rst = 1'b0;
    last = 1'b1;
    chk("rst_start", res_start, 1'b0);
    chk("rst_rsp", rsp_valid, 2'b00);
    chk("rst_o0", rsp_o0, '0);
    chk("rst_i0", res_i0, '0);
    chk("rst_err", rsp_err, 1'b0);

    // Spec example: done at T+4, response at T+5
    run_txn(1'b1, 1'b0, 5'b10110, 5'b01001, '0, '0, 2, 5'b00011, 5'b10000);

    // Index preservation on the ascending buses
    v1b = '0; v1b[-2] = 1'b1;
    s0 = '0; s0[2] = 1'b1;
    run_txn(1'b0, 1'b1, '0, '0, '0, v1b, 0, '0, s0);
    chk("idx_res_i1_lo", res_i1[-2], 1'b1);
    chk("idx_res_i1_hi", res_i1[2], 1'b0);
    chk("idx_rsp_o1_hi", rsp_o1[2], 1'b1);
    chk("idx_rsp_o1_lo", rsp_o1[-2], 1'b0);

    // Reset while waiting on the resource
    req0_valid = 1'b1; req0_i0 = 5'b10110; req0_i1 = 5'b01001;
    step();
    req0_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    last = 1'b1;
    chk("mid_rst_start", res_start, 1'b0);
    chk("mid_rst_i0", res_i0, '0);
    chk("mid_rst_i1", res_i1, '0);
    chk("mid_rst_o1", rsp_o1, '0);
    chk("mid_rst_rsp", rsp_valid, 2'b00);
    res_done = 1'b1; res_o0 = 5'b11111; res_o1 = 5'b11111;
    step();
    res_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("late_done_rsp", rsp_valid, 2'b00);
      chk("late_done_start", res_start, 1'b0);
      step();
    end

    // Both valid continuously: alternation starting at requester 0
    for (int k = 0; k < 4; k++)
      run_txn(1'b1, 1'b1, W'($urandom), W'($urandom), W'($urandom), W'($urandom),
              k, W'($urandom), W'($urandom));

    // Expiry boundary and long wait
    run_txn(1'b1, 1'b0, 5'b00111, 5'b11000, '0, '0, TIMEOUT - 1, 5'b01010, 5'b00101);
    run_txn(1'b0, 1'b1, '0, '0, 5'b11100, 5'b00011, TIMEOUT + 4, 5'b10101, 5'b01011);
    run_txn(1'b1, 1'b1, 5'b01100, 5'b10011, 5'b00110, 5'b11001, 99, 5'b11011, 5'b00100);

    // Randomized traffic with idle gaps
    for (int n = 0; n < 24; n++) begin
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk("gap_ready", {req0_ready, req1_ready}, 2'b00);
        chk("gap_rsp", rsp_valid, 2'b00);
        step();
      end
      rv0 = 1'($urandom);
      rv1 = rv0 ? 1'($urandom) : 1'b1;
      r0 = W'($urandom); r1 = W'($urandom); s0 = W'($urandom); s1 = W'($urandom);
      run_txn(rv0, rv1, r0, s0, r1, s1, int'($urandom_range(0, 6)), W'($urandom), W'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
